// File: rtl/cacc_pwr_pkg.sv
// Shared state encoding, default timing values and helpers for the CACC
// Q-channel power controller and its counters.
package cacc_pwr_pkg;

    localparam int unsigned CNT_W            = 8;
    localparam int unsigned IDLE_HOLD_DEF    = 4;
    localparam int unsigned PWR_SETTLE_DEF   = 8;
    localparam int unsigned DENY_BACKOFF_DEF = 16;
    localparam logic [7:0]  DENY_CNT_MAX     = 8'hFF;

    typedef enum logic [2:0] {
        ST_RUN     = 3'd0,
        ST_REQ     = 3'd1,
        ST_DENIED  = 3'd2,
        ST_ISO     = 3'd3,
        ST_OFF     = 3'd4,
        ST_SETTLE  = 3'd5,
        ST_RESTORE = 3'd6,
        ST_EXIT    = 3'd7
    } pwr_state_e;

    // Clamp a timing parameter into the range the down-counters can hold.
    function automatic logic [CNT_W-1:0] cnt_load(input int unsigned val);
        int unsigned clamped;
        clamped = (val > ((2 ** CNT_W) - 1)) ? ((2 ** CNT_W) - 1) : val;
        return clamped[CNT_W-1:0];
    endfunction

endpackage

// File: rtl/cacc_pwr_cnt.sv
// Loadable down-counter with a zero flag. Load wins over decrement, and the
// count parks at zero instead of wrapping.
module cacc_pwr_cnt #(
    parameter int unsigned   W       = 8,
    parameter logic [W-1:0]  RST_VAL = '0
) (
    input  logic         nvdla_core_clk,
    input  logic         nvdla_core_rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] count;

    // Count register: reload, or step down toward zero and hold there.
    always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
        if (nvdla_core_rst) begin
            count <= RST_VAL;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/cacc_qch_pwr_ctrl.sv
// Q-channel power controller for the CACC gated domain. Sequences the
// standby handshake, isolation, power switch, settle wait and retention
// restore, and backs off for a while after the CACC block denies a request.
// All control outputs are decoded from the state so reset clears them at once.
module cacc_qch_pwr_ctrl #(
    parameter int unsigned IDLE_HOLD    = cacc_pwr_pkg::IDLE_HOLD_DEF,
    parameter int unsigned PWR_SETTLE   = cacc_pwr_pkg::PWR_SETTLE_DEF,
    parameter int unsigned DENY_BACKOFF = cacc_pwr_pkg::DENY_BACKOFF_DEF
) (
    input  logic       nvdla_core_clk,
    input  logic       nvdla_core_rst,
    input  logic       idle_req,
    input  logic       qacceptn,
    input  logic       qdeny,
    output logic       qreqn,
    output logic       pr_restore,
    output logic       iso_en,
    output logic       pwr_off,
    output logic [2:0] pwr_state,
    output logic [7:0] deny_cnt
);

    import cacc_pwr_pkg::*;

    // Settle counter is loaded with N-1 so the FSM spends exactly N cycles
    // in SETTLE; a zero setting still gives one settle cycle.
    localparam logic [CNT_W-1:0] IDLE_LD    = cnt_load(IDLE_HOLD);
    localparam logic [CNT_W-1:0] SETTLE_LD  = (PWR_SETTLE == 0) ? '0 : cnt_load(PWR_SETTLE - 1);
    localparam logic [CNT_W-1:0] BACKOFF_LD = cnt_load(DENY_BACKOFF);

    pwr_state_e state;
    pwr_state_e state_nxt;

    logic idle_zero;
    logic settle_zero;
    logic backoff_zero;
    logic idle_load;
    logic settle_load;
    logic deny_hit;

    // A deny seen while requesting both bumps the deny count and arms backoff.
    assign deny_hit    = (state == ST_REQ) && qdeny;
    assign idle_load   = (state != ST_RUN) || !idle_req;
    assign settle_load = (state != ST_SETTLE);

    cacc_pwr_cnt #(
        .W       (CNT_W),
        .RST_VAL (IDLE_LD)
    ) u_idle_cnt (
        .nvdla_core_clk (nvdla_core_clk),
        .nvdla_core_rst (nvdla_core_rst),
        .load           (idle_load),
        .load_val       (IDLE_LD),
        .dec            (backoff_zero),
        .zero           (idle_zero)
    );

    cacc_pwr_cnt #(
        .W       (CNT_W),
        .RST_VAL (SETTLE_LD)
    ) u_settle_cnt (
        .nvdla_core_clk (nvdla_core_clk),
        .nvdla_core_rst (nvdla_core_rst),
        .load           (settle_load),
        .load_val       (SETTLE_LD),
        .dec            (1'b1),
        .zero           (settle_zero)
    );

    cacc_pwr_cnt #(
        .W       (CNT_W),
        .RST_VAL ('0)
    ) u_backoff_cnt (
        .nvdla_core_clk (nvdla_core_clk),
        .nvdla_core_rst (nvdla_core_rst),
        .load           (deny_hit),
        .load_val       (BACKOFF_LD),
        .dec            (1'b1),
        .zero           (backoff_zero)
    );

    // State register.
    always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
        if (nvdla_core_rst) begin
            state <= ST_RUN;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode and state-decoded control outputs.
    always_comb begin
        state_nxt  = state;
        qreqn      = 1'b1;
        pr_restore = 1'b0;
        iso_en     = 1'b0;
        pwr_off    = 1'b0;
        case (state)
            ST_RUN: begin
                if (idle_req && idle_zero && backoff_zero && qacceptn && !qdeny) begin
                    state_nxt = ST_REQ;
                end
            end
            ST_REQ: begin
                qreqn = 1'b0;
                if (qdeny) begin
                    state_nxt = ST_DENIED;
                end else if (!qacceptn) begin
                    state_nxt = ST_ISO;
                end
            end
            ST_DENIED: begin
                if (!qdeny && qacceptn) begin
                    state_nxt = ST_RUN;
                end
            end
            ST_ISO: begin
                qreqn     = 1'b0;
                iso_en    = 1'b1;
                state_nxt = ST_OFF;
            end
            ST_OFF: begin
                qreqn   = 1'b0;
                iso_en  = 1'b1;
                pwr_off = 1'b1;
                if (!idle_req) begin
                    state_nxt = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                qreqn  = 1'b0;
                iso_en = 1'b1;
                if (settle_zero) begin
                    state_nxt = ST_RESTORE;
                end
            end
            ST_RESTORE: begin
                qreqn      = 1'b0;
                iso_en     = 1'b1;
                pr_restore = 1'b1;
                state_nxt  = ST_EXIT;
            end
            ST_EXIT: begin
                iso_en = 1'b1;
                if (qacceptn) begin
                    state_nxt = ST_RUN;
                end
            end
            default: begin
                state_nxt = ST_RUN;
            end
        endcase
    end

    // Saturating count of denies since reset.
    always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
        if (nvdla_core_rst) begin
            deny_cnt <= 8'd0;
        end else if (deny_hit && (deny_cnt != DENY_CNT_MAX)) begin
            deny_cnt <= deny_cnt + 8'd1;
        end
    end

    assign pwr_state = state;

endmodule

// File: tb/tb_cacc_qch_pwr_ctrl.sv
// Directed bench for the CACC Q-channel power controller: power-down,
// power-up, deny backoff, deny saturation, idle drop during request and
// reset in the middle of a power-down.
module tb_cacc_qch_pwr_ctrl;

    localparam logic [2:0] S_RUN     = 3'd0;
    localparam logic [2:0] S_REQ     = 3'd1;
    localparam logic [2:0] S_DENIED  = 3'd2;
    localparam logic [2:0] S_ISO     = 3'd3;
    localparam logic [2:0] S_OFF     = 3'd4;
    localparam logic [2:0] S_SETTLE  = 3'd5;
    localparam logic [2:0] S_RESTORE = 3'd6;
    localparam logic [2:0] S_EXIT    = 3'd7;

    logic       clk = 1'b0;
    logic       rst;
    logic       idle_req;
    logic       qacceptn;
    logic       qdeny;
    logic       qreqn;
    logic       pr_restore;
    logic       iso_en;
    logic       pwr_off;
    logic [2:0] pwr_state;
    logic [7:0] deny_cnt;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    cacc_qch_pwr_ctrl dut (
        .nvdla_core_clk (clk),
        .nvdla_core_rst (rst),
        .idle_req       (idle_req),
        .qacceptn       (qacceptn),
        .qdeny          (qdeny),
        .qreqn          (qreqn),
        .pr_restore     (pr_restore),
        .iso_en         (iso_en),
        .pwr_off        (pwr_off),
        .pwr_state      (pwr_state),
        .deny_cnt       (deny_cnt)
    );

    task automatic test_reset();
        rst      = 1'b1;
        idle_req = 1'b0;
        qacceptn = 1'b1;
        qdeny    = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if ({qreqn, pr_restore, iso_en, pwr_off} !== 4'b1000) begin
            bad++;
            $display("[TB] FAIL reset_ctrl: got %b expected 1000", {qreqn, pr_restore, iso_en, pwr_off});
        end
        total++;
        if (pwr_state !== S_RUN) begin
            bad++;
            $display("[TB] FAIL reset_state: got %0d expected %0d", pwr_state, S_RUN);
        end
        total++;
        if (deny_cnt !== 8'd0) begin
            bad++;
            $display("[TB] FAIL reset_deny_cnt: got %0d expected 0", deny_cnt);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_power_down();
        idle_req = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            total++;
            if (qreqn !== 1'b1) begin
                bad++;
                $display("[TB] FAIL idle_hold_qreqn cycle %0d: got %b expected 1", k, qreqn);
            end
        end
        @(negedge clk);
        total++;
        if ({qreqn, pwr_state} !== {1'b0, S_REQ}) begin
            bad++;
            $display("[TB] FAIL req_entry: got qreqn=%b state=%0d expected qreqn=0 state=%0d", qreqn, pwr_state, S_REQ);
        end
        qacceptn = 1'b0;
        @(negedge clk);
        total++;
        if ({pwr_state, iso_en, pwr_off} !== {S_ISO, 1'b1, 1'b0}) begin
            bad++;
            $display("[TB] FAIL iso_entry: got state=%0d iso=%b off=%b expected state=%0d iso=1 off=0", pwr_state, iso_en, pwr_off, S_ISO);
        end
        @(negedge clk);
        total++;
        if ({pwr_state, iso_en, pwr_off} !== {S_OFF, 1'b1, 1'b1}) begin
            bad++;
            $display("[TB] FAIL off_entry: got state=%0d iso=%b off=%b expected state=%0d iso=1 off=1", pwr_state, iso_en, pwr_off, S_OFF);
        end
        repeat (3) @(negedge clk);
        total++;
        if (pwr_state !== S_OFF) begin
            bad++;
            $display("[TB] FAIL off_hold: got %0d expected %0d", pwr_state, S_OFF);
        end
    endtask

    task automatic test_power_up();
        logic [3:0] idx;
        idle_req = 1'b0;
        @(negedge clk);
        total++;
        if ({pwr_state, pwr_off, iso_en, qreqn} !== {S_SETTLE, 1'b0, 1'b1, 1'b0}) begin
            bad++;
            $display("[TB] FAIL settle_entry: got state=%0d off=%b iso=%b qreqn=%b expected state=%0d off=0 iso=1 qreqn=0", pwr_state, pwr_off, iso_en, qreqn, S_SETTLE);
        end
        for (int i = 1; i <= 7; i++) begin
            idx      = 4'(i);
            idle_req = idx[0];
            @(negedge clk);
            total++;
            if ({pwr_state, pr_restore} !== {S_SETTLE, 1'b0}) begin
                bad++;
                $display("[TB] FAIL settle_hold cycle %0d: got state=%0d pr=%b expected state=%0d pr=0", i + 1, pwr_state, pr_restore, S_SETTLE);
            end
        end
        @(negedge clk);
        total++;
        if ({pwr_state, pr_restore, qreqn} !== {S_RESTORE, 1'b1, 1'b0}) begin
            bad++;
            $display("[TB] FAIL restore_pulse: got state=%0d pr=%b qreqn=%b expected state=%0d pr=1 qreqn=0", pwr_state, pr_restore, qreqn, S_RESTORE);
        end
        idle_req = 1'b1;
        @(negedge clk);
        total++;
        if ({pwr_state, pr_restore, qreqn, iso_en} !== {S_EXIT, 1'b0, 1'b1, 1'b1}) begin
            bad++;
            $display("[TB] FAIL exit_entry: got state=%0d pr=%b qreqn=%b iso=%b expected state=%0d pr=0 qreqn=1 iso=1", pwr_state, pr_restore, qreqn, iso_en, S_EXIT);
        end
        idle_req = 1'b0;
        @(negedge clk);
        total++;
        if ({pwr_state, iso_en} !== {S_EXIT, 1'b1}) begin
            bad++;
            $display("[TB] FAIL exit_wait_accept: got state=%0d iso=%b expected state=%0d iso=1", pwr_state, iso_en, S_EXIT);
        end
        qacceptn = 1'b1;
        @(negedge clk);
        total++;
        if ({pwr_state, iso_en, qreqn} !== {S_RUN, 1'b0, 1'b1}) begin
            bad++;
            $display("[TB] FAIL exit_to_run: got state=%0d iso=%b qreqn=%b expected state=%0d iso=0 qreqn=1", pwr_state, iso_en, qreqn, S_RUN);
        end
    endtask

    task automatic test_deny_backoff();
        bit fell;
        idle_req = 1'b1;
        repeat (5) @(negedge clk);
        total++;
        if ({pwr_state, qreqn} !== {S_REQ, 1'b0}) begin
            bad++;
            $display("[TB] FAIL deny_req_entry: got state=%0d qreqn=%b expected state=%0d qreqn=0", pwr_state, qreqn, S_REQ);
        end
        qdeny = 1'b1;
        @(negedge clk);
        total++;
        if ({pwr_state, qreqn, deny_cnt} !== {S_DENIED, 1'b1, 8'd1}) begin
            bad++;
            $display("[TB] FAIL deny_entry: got state=%0d qreqn=%b cnt=%0d expected state=%0d qreqn=1 cnt=1", pwr_state, qreqn, deny_cnt, S_DENIED);
        end
        qdeny = 1'b0;
        fell  = 1'b0;
        // 16 backoff cycles plus a fresh 4-cycle idle hold keep qreqn high.
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (qreqn !== 1'b1) fell = 1'b1;
        end
        total++;
        if (fell !== 1'b0) begin
            bad++;
            $display("[TB] FAIL backoff_hold: got early qreqn fall=%b expected 0", fell);
        end
        @(negedge clk);
        total++;
        if ({pwr_state, qreqn} !== {S_REQ, 1'b0}) begin
            bad++;
            $display("[TB] FAIL backoff_rerequest: got state=%0d qreqn=%b expected state=%0d qreqn=0", pwr_state, qreqn, S_REQ);
        end
    endtask

    task automatic test_deny_saturation();
        int exp_cnt;
        bit got;
        exp_cnt = 1;
        for (int n = 2; n <= 300; n++) begin
            got = 1'b0;
            for (int w = 0; w < 40; w++) begin
                if (pwr_state === S_REQ) begin
                    got = 1'b1;
                    break;
                end
                @(negedge clk);
            end
            if (!got) begin
                total++;
                bad++;
                $display("[TB] FAIL sat_wait_req deny %0d: got state=%0d expected %0d within 40 cycles", n, pwr_state, S_REQ);
                return;
            end
            qdeny = 1'b1;
            @(negedge clk);
            qdeny   = 1'b0;
            exp_cnt = (exp_cnt < 255) ? exp_cnt + 1 : 255;
            if (n == 254 || n == 255 || n == 256 || n == 300) begin
                total++;
                if (deny_cnt !== 8'(exp_cnt)) begin
                    bad++;
                    $display("[TB] FAIL deny_sat after %0d denies: got %0d expected %0d", n, deny_cnt, exp_cnt);
                end
            end
        end
    endtask

    task automatic test_idle_drop_in_req();
        bit got;
        got = 1'b0;
        for (int w = 0; w < 40; w++) begin
            if (pwr_state === S_REQ) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
        total++;
        if (!got) begin
            bad++;
            $display("[TB] FAIL drop_wait_req: got state=%0d expected %0d within 40 cycles", pwr_state, S_REQ);
            return;
        end
        idle_req = 1'b0;
        @(negedge clk);
        total++;
        if ({pwr_state, qreqn} !== {S_REQ, 1'b0}) begin
            bad++;
            $display("[TB] FAIL drop_keeps_req: got state=%0d qreqn=%b expected state=%0d qreqn=0", pwr_state, qreqn, S_REQ);
        end
        qacceptn = 1'b0;
        @(negedge clk);
        total++;
        if (pwr_state !== S_ISO) begin
            bad++;
            $display("[TB] FAIL drop_iso: got %0d expected %0d", pwr_state, S_ISO);
        end
        @(negedge clk);
        total++;
        if ({pwr_state, pwr_off} !== {S_OFF, 1'b1}) begin
            bad++;
            $display("[TB] FAIL drop_off: got state=%0d off=%b expected state=%0d off=1", pwr_state, pwr_off, S_OFF);
        end
        @(negedge clk);
        total++;
        if (pwr_state !== S_SETTLE) begin
            bad++;
            $display("[TB] FAIL drop_settle: got %0d expected %0d", pwr_state, S_SETTLE);
        end
        got = 1'b0;
        for (int w = 0; w < 20; w++) begin
            if (pwr_state === S_EXIT) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
        total++;
        if (!got) begin
            bad++;
            $display("[TB] FAIL drop_wait_exit: got state=%0d expected %0d within 20 cycles", pwr_state, S_EXIT);
        end
        qacceptn = 1'b1;
        @(negedge clk);
        total++;
        if ({pwr_state, iso_en} !== {S_RUN, 1'b0}) begin
            bad++;
            $display("[TB] FAIL drop_back_run: got state=%0d iso=%b expected state=%0d iso=0", pwr_state, iso_en, S_RUN);
        end
    endtask

    task automatic test_reset_in_off();
        bit stray;
        idle_req = 1'b1;
        repeat (5) @(negedge clk);
        qacceptn = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if (pwr_state !== S_OFF) begin
            bad++;
            $display("[TB] FAIL rst_off_reach: got %0d expected %0d", pwr_state, S_OFF);
        end
        #2;
        rst = 1'b1;
        #1;
        total++;
        if ({qreqn, pr_restore, iso_en, pwr_off, pwr_state, deny_cnt} !== {4'b1000, S_RUN, 8'd0}) begin
            bad++;
            $display("[TB] FAIL rst_async_clear: got qreqn=%b pr=%b iso=%b off=%b state=%0d cnt=%0d expected 1 0 0 0 %0d 0", qreqn, pr_restore, iso_en, pwr_off, pwr_state, deny_cnt, S_RUN);
        end
        qacceptn = 1'b1;
        idle_req = 1'b0;
        @(negedge clk);
        rst   = 1'b0;
        stray = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (pr_restore !== 1'b0 || pwr_state !== S_RUN) stray = 1'b1;
        end
        total++;
        if (stray !== 1'b0) begin
            bad++;
            $display("[TB] FAIL rst_no_restore: got stray activity=%b expected 0", stray);
        end
    endtask

    task automatic test_first_req_after_reset();
        idle_req = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            total++;
            if (qreqn !== ((k < 5) ? 1'b1 : 1'b0)) begin
                bad++;
                $display("[TB] FAIL first_req_hold cycle %0d: got %b expected %b", k, qreqn, (k < 5) ? 1'b1 : 1'b0);
            end
        end
        idle_req = 1'b0;
    endtask

    initial begin
        test_reset();
        test_power_down();
        test_power_up();
        test_deny_backoff();
        test_deny_saturation();
        test_idle_drop_in_req();
        test_reset_in_off();
        test_first_req_after_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cacc_qch_pwr_ctrl.md
CACC_QCH_PWR_CTRL -- requirements
Module: cacc_qch_pwr_ctrl

Interface
REQ-001 SHALL have parameters: IDLE_HOLD, 4, cycles idle_req must stay high before a Q-channel request is issued.
REQ-002 SHALL have parameter PWR_SETTLE, 8, cycles waited after power-switch on before restore.
REQ-003 SHALL have parameter DENY_BACKOFF, 16, cycles blocked from re-requesting after a deny.
REQ-004 SHALL have ports: nvdla_core_clk  in  1  single clock, all logic rising-edge.
REQ-005 nvdla_core_rst  in  1  asynchronous, active-high reset.
REQ-006 idle_req  in  1  PMU level request for standby (1 = wants power-down).
REQ-007 qacceptn  in  1  Q-channel accept from the CACC Q-channel block.
REQ-008 qdeny  in  1  Q-channel deny from the CACC Q-channel block.
REQ-009 qreqn  out  1  Q-channel request to the CACC block, active-low.
REQ-010 pr_restore  out  1  one-cycle retention-restore strobe to the CACC block.
REQ-011 iso_en  out  1  output isolation enable for the gated domain.
REQ-012 pwr_off  out  1  power-switch off control for the gated domain.
REQ-013 pwr_state  out  3  current FSM state encoding.
REQ-014 deny_cnt  out  8  saturating count of denies since reset.

Function
REQ-015 FSM states: RUN, REQ, DENIED, ISO, OFF, SETTLE, RESTORE, EXIT.
REQ-016 RUN: qreqn=1; idle counter counts while idle_req=1 and backoff=0; clears when idle_req=0.
REQ-017 RUN->REQ when idle counter reaches IDLE_HOLD and qacceptn=1 and qdeny=0; qreqn=0 from the next cycle.
REQ-018 REQ: hold qreqn=0; qacceptn=0 with qdeny=0 -> ISO; qdeny=1 -> DENIED; qdeny has priority if both change together.
REQ-019 DENIED: qreqn=1 immediately; deny_cnt +1, saturating at 255; backoff loads DENY_BACKOFF; ->RUN when qdeny=0 and qacceptn=1.
REQ-020 ISO: iso_en=1 for one cycle, then ->OFF.
REQ-021 OFF: iso_en=1, pwr_off=1; stays while idle_req=1; idle_req=0 -> SETTLE.
REQ-022 SETTLE: pwr_off=0, iso_en=1; counts PWR_SETTLE cycles, then ->RESTORE.
REQ-023 RESTORE: pr_restore=1 for exactly one cycle with qreqn=0 and qacceptn=0 (standby); ->EXIT.
REQ-024 EXIT: qreqn=1, pr_restore=0 on the cycle after RESTORE; iso_en=0 once qacceptn=1; then ->RUN.
REQ-025 qreqn SHALL fall only when qacceptn=1 and qdeny=0 held the previous cycle, and rise only when qacceptn==qdeny held the previous cycle.
REQ-026 idle_req dropping in REQ SHALL NOT abort the handshake; the FSM completes to OFF, then exits.
REQ-027 idle_req toggling in SETTLE/RESTORE/EXIT SHALL be ignored until RUN.
REQ-028 pr_restore SHALL never assert outside RESTORE; pwr_off SHALL never assert while iso_en=0.
REQ-029 Backoff counter decrements in every state until zero; DENY_BACKOFF=0 disables backoff.

Reset
REQ-030 Asserting nvdla_core_rst at any time, including mid-sequence, SHALL force RUN, qreqn=1, pr_restore=0, iso_en=0, pwr_off=0, pwr_state=RUN, deny_cnt=0, and clear all counters asynchronously.
REQ-031 First RUN->REQ after reset release SHALL need a full IDLE_HOLD count.

Structure
REQ-032 State enum, its 3-bit encoding and the default parameter values SHALL live in shared package cacc_pwr_pkg.
REQ-033 One sub-module, cacc_pwr_cnt (loadable down-counter with zero flag), SHALL be instanced for idle, settle and backoff timing.

Verification
REQ-034 idle_req=1 for 4 cycles, qacceptn=1, qdeny=0 -> qreqn falls in cycle 5; qacceptn falls -> iso_en=1, then pwr_off=1 next cycle.
REQ-035 From OFF drop idle_req -> pwr_off=0, 8 SETTLE cycles, pr_restore=1 one cycle, qreqn=1 next cycle, iso_en=0 after qacceptn=1.
REQ-036 In REQ drive qdeny=1 -> qreqn=1 next cycle, deny_cnt=1, no new qreqn fall for 16 cycles despite idle_req=1.
REQ-037 Force 300 denies -> deny_cnt saturates at 255.
REQ-038 Assert nvdla_core_rst while in OFF -> all outputs at reset values same cycle, no pr_restore pulse after release.
REQ-039 Formal: the four Q-channel protocol rules and REQ-028 hold for all reachable states.
